// File: rtl/stream_progress_monitor.sv
// Purpose: watches NCH valid/ready streams. Per channel it tracks the handshake
// index inside the current frame, the number of completed frames and how long
// the channel has gone without progress. A small run-control FSM ends the run
// when the producer signals done, when any channel stalls (deadlock), or when
// the run cycle budget is used up (timeout).
// Ports:
//   clk_pc, rstn_nw  monitor clock; asynchronous active-low reset
//   start_i          IDLE->RUN request (ignored outside IDLE)
//   clear_i          synchronous return to IDLE; zeroes every counter and flag
//   valid_i/ready_i  per-channel handshake pair
//   done_i           all-tiles-done indication
//   addr_o           per-channel in-frame handshake index, packed NCH x CNT_W
//   frame_cnt_o      per-channel completed frame count, packed NCH x 16
//   stall_o          per-channel stall flag
//   state_o          0 IDLE, 1 RUN, 2 DONE, 3 DEADLOCK, 4 TIMEOUT
//   quit_o           one-cycle pulse on entering a terminal state
module stream_progress_monitor #(
  parameter int unsigned NCH            = 4,
  parameter int unsigned FRAME_LEN      = 1024,
  parameter int unsigned STALL_THRESH   = 1000000,
  parameter int unsigned STALL_MODE     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 32'hFFFF_FFFF,
  localparam int unsigned CNT_W         = $clog2(FRAME_LEN)
) (
  input  logic                 clk_pc,
  input  logic                 rstn_nw,
  input  logic                 start_i,
  input  logic                 clear_i,
  input  logic [NCH-1:0]       valid_i,
  input  logic [NCH-1:0]       ready_i,
  input  logic                 done_i,
  output logic [NCH*CNT_W-1:0] addr_o,
  output logic [NCH*16-1:0]    frame_cnt_o,
  output logic [NCH-1:0]       stall_o,
  output logic [2:0]           state_o,
  output logic                 quit_o
);

  localparam int unsigned FRM_W   = 16;
  localparam int unsigned STALL_W = 24;
  localparam int unsigned TMO_W   = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_DONE     = 3'd2,
    ST_DEADLOCK = 3'd3,
    ST_TIMEOUT  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               quit_q, quit_d;
  logic [CNT_W-1:0]   addr_q  [NCH];
  logic [CNT_W-1:0]   addr_d  [NCH];
  logic [FRM_W-1:0]   frame_q [NCH];
  logic [FRM_W-1:0]   frame_d [NCH];
  logic [STALL_W-1:0] scnt_q  [NCH];
  logic [STALL_W-1:0] scnt_d  [NCH];
  logic [NCH-1:0]     stall_q, stall_d;
  logic [TMO_W-1:0]   tcnt_q, tcnt_d;
  logic [NCH-1:0]     hs_c;
  logic [NCH-1:0]     nop_c;
  logic               run_c;

  assign hs_c  = valid_i & ready_i;
  assign run_c = (state_q == ST_RUN);

  // No-progress condition; mode 0 ignores back-pressure at a frame boundary
  always_comb begin
    nop_c = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (STALL_MODE == 0) begin
        nop_c[i] = valid_i[i] & ~ready_i[i] & (addr_q[i] != '0);
      end else begin
        nop_c[i] = valid_i[i] & ~ready_i[i];
      end
    end
  end

  // Per-channel address, frame and stall counters; frozen outside RUN
  always_comb begin
    stall_d = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      addr_d[i]  = addr_q[i];
      frame_d[i] = frame_q[i];
      scnt_d[i]  = scnt_q[i];
      if (clear_i) begin
        addr_d[i]  = '0;
        frame_d[i] = '0;
        scnt_d[i]  = '0;
      end else if (run_c) begin
        if (hs_c[i]) begin
          scnt_d[i] = '0;
          if (addr_q[i] == CNT_W'(FRAME_LEN - 1)) begin
            addr_d[i]  = '0;
            frame_d[i] = frame_q[i] + FRM_W'(1);
          end else begin
            addr_d[i] = addr_q[i] + CNT_W'(1);
          end
        end else if (nop_c[i] && (scnt_q[i] != STALL_W'(STALL_THRESH))) begin
          scnt_d[i] = scnt_q[i] + STALL_W'(1);
        end
      end
      // Flag tracks the registered counter exactly
      stall_d[i] = (scnt_d[i] == STALL_W'(STALL_THRESH));
    end
  end

  // Run cycle budget; restarts on every IDLE->RUN transition
  always_comb begin
    tcnt_d = tcnt_q;
    if (clear_i) begin
      tcnt_d = '0;
    end else if ((state_q == ST_IDLE) && start_i) begin
      tcnt_d = '0;
    end else if (run_c && (tcnt_q != TMO_W'(TIMEOUT_CYCLES))) begin
      tcnt_d = tcnt_q + TMO_W'(1);
    end
  end

  // Run-control next state; exit priority done > deadlock > timeout
  always_comb begin
    state_d = state_q;
    quit_d  = 1'b0;
    if (clear_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start_i) state_d = ST_RUN;
        ST_RUN: begin
          if (done_i) begin
            state_d = ST_DONE;
          end else if (|stall_q) begin
            state_d = ST_DEADLOCK;
          end else if (tcnt_q == TMO_W'(TIMEOUT_CYCLES)) begin
            state_d = ST_TIMEOUT;
          end
        end
        ST_DONE, ST_DEADLOCK, ST_TIMEOUT: state_d = state_q;
        default: state_d = ST_IDLE;
      endcase
      quit_d = run_c && (state_d != ST_RUN);
    end
  end

  always_ff @(posedge clk_pc or negedge rstn_nw) begin
    if (!rstn_nw) begin
      state_q <= ST_IDLE;
      quit_q  <= 1'b0;
      tcnt_q  <= '0;
      stall_q <= '0;
      for (int i = 0; i < int'(NCH); i++) begin
        addr_q[i]  <= '0;
        frame_q[i] <= '0;
        scnt_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      quit_q  <= quit_d;
      tcnt_q  <= tcnt_d;
      stall_q <= stall_d;
      for (int i = 0; i < int'(NCH); i++) begin
        addr_q[i]  <= addr_d[i];
        frame_q[i] <= frame_d[i];
        scnt_q[i]  <= scnt_d[i];
      end
    end
  end

  for (genvar g = 0; g < int'(NCH); g++) begin : g_pack
    assign addr_o[g*CNT_W +: CNT_W]      = addr_q[g];
    assign frame_cnt_o[g*FRM_W +: FRM_W] = frame_q[g];
  end

  assign stall_o = stall_q;
  assign state_o = 3'(state_q);
  assign quit_o  = quit_q;

endmodule

// File: tb/tb_stream_progress_monitor.sv
// Directed bench: two instances share stimulus, one per stall mode
// (NCH=2, FRAME_LEN=4, STALL_THRESH=8, TIMEOUT_CYCLES=100).
module tb_stream_progress_monitor;

  logic        clk_pc;
  logic        rstn_nw;
  logic        start_i;
  logic        clear_i;
  logic [1:0]  valid_i;
  logic [1:0]  ready_i;
  logic        done_i;

  logic [3:0]  addr0, addr1;
  logic [31:0] frm0, frm1;
  logic [1:0]  stall0, stall1;
  logic [2:0]  st0, st1;
  logic        quit0, quit1;

  int checks;
  int failures;

  stream_progress_monitor #(
    .NCH(2), .FRAME_LEN(4), .STALL_THRESH(8), .STALL_MODE(0), .TIMEOUT_CYCLES(100)
  ) u_dut_m0 (
    .clk_pc(clk_pc), .rstn_nw(rstn_nw), .start_i(start_i), .clear_i(clear_i),
    .valid_i(valid_i), .ready_i(ready_i), .done_i(done_i),
    .addr_o(addr0), .frame_cnt_o(frm0), .stall_o(stall0), .state_o(st0), .quit_o(quit0)
  );

  stream_progress_monitor #(
    .NCH(2), .FRAME_LEN(4), .STALL_THRESH(8), .STALL_MODE(1), .TIMEOUT_CYCLES(100)
  ) u_dut_m1 (
    .clk_pc(clk_pc), .rstn_nw(rstn_nw), .start_i(start_i), .clear_i(clear_i),
    .valid_i(valid_i), .ready_i(ready_i), .done_i(done_i),
    .addr_o(addr1), .frame_cnt_o(frm1), .stall_o(stall1), .state_o(st1), .quit_o(quit1)
  );

  initial clk_pc = 1'b0;
  always #5 clk_pc = ~clk_pc;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_pc);
      #1;
    end
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    step(1);
    clear_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    rstn_nw  = 1'b0;
    start_i  = 1'b0;
    clear_i  = 1'b0;
    valid_i  = 2'b00;
    ready_i  = 2'b00;
    done_i   = 1'b0;

    #1;
    chk("rst_state", 32'(st0), 32'd0);
    chk("rst_addr", 32'(addr0), 32'd0);
    chk("rst_frame", frm0, 32'd0);
    chk("rst_stall_quit", {29'd0, stall0, quit0}, 32'd0);
    #11 rstn_nw = 1'b1;
    step(1);

    // Streaming on ch0; handshake during the start cycle is not counted
    start_i = 1'b1; valid_i = 2'b01; ready_i = 2'b01;
    step(1);
    start_i = 1'b0;
    chk("a_run", 32'(st0), 32'd1);
    chk("a_start_hs_ignored", 32'(addr0), 32'd0);
    step(9);
    chk("a_addr0", 32'(addr0[1:0]), 32'd1);
    chk("a_frame0", 32'(frm0[15:0]), 32'd2);
    chk("a_addr1", 32'(addr0[3:2]), 32'd0);
    chk("a_frame1", 32'(frm0[31:16]), 32'd0);
    chk("a_stall", 32'(stall0), 32'd0);
    // Done with a handshake in the same cycle: still counted
    done_i = 1'b1;
    step(1);
    done_i = 1'b0;
    chk("a_done", 32'(st0), 32'd2);
    chk("a_quit", 32'(quit0), 32'd1);
    chk("a_exit_hs_counted", 32'(addr0[1:0]), 32'd2);
    step(1);
    chk("a_quit_single", 32'(quit0), 32'd0);
    chk("a_sticky", 32'(st0), 32'd2);
    chk("a_hold_outside_run", 32'(addr0[1:0]), 32'd2);
    valid_i = 2'b00; ready_i = 2'b00;
    do_clear();
    chk("a_clr_state", 32'(st0), 32'd0);
    chk("a_clr_addr", 32'(addr0), 32'd0);
    chk("a_clr_frame", frm0, 32'd0);

    // Mid-frame stall on ch0 leads to deadlock
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    valid_i = 2'b01; ready_i = 2'b01;
    step(3);
    chk("b_addr0", 32'(addr0[1:0]), 32'd3);
    ready_i = 2'b00;
    step(7);
    chk("b_no_stall_7", 32'(stall0), 32'd0);
    step(1);
    chk("b_stall_8", 32'(stall0), 32'd1);
    chk("b_still_run", 32'(st0), 32'd1);
    chk("b_quit_low", 32'(quit0), 32'd0);
    step(1);
    chk("b_deadlock", 32'(st0), 32'd3);
    chk("b_quit", 32'(quit0), 32'd1);
    step(1);
    chk("b_quit_single", 32'(quit0), 32'd0);
    chk("b_addr_hold", 32'(addr0[1:0]), 32'd3);
    valid_i = 2'b00;
    do_clear();
    chk("b_clr_stall", 32'(stall0), 32'd0);

    // Back-pressure at a frame boundary: mode 0 ignores it, mode 1 deadlocks
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    valid_i = 2'b01; ready_i = 2'b00;
    step(8);
    chk("c_m1_stall", 32'(stall1), 32'd1);
    chk("c_m0_no_stall", 32'(stall0), 32'd0);
    step(1);
    chk("c_m1_deadlock", 32'(st1), 32'd3);
    chk("c_m1_quit", 32'(quit1), 32'd1);
    step(3);
    chk("c_m0_run", 32'(st0), 32'd1);
    chk("c_m0_no_stall_late", 32'(stall0), 32'd0);
    valid_i = 2'b00;
    do_clear();

    // done_i beats a simultaneous stall; clear beats start
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    valid_i = 2'b10; ready_i = 2'b10;
    step(1);
    chk("d_addr1", 32'(addr0[3:2]), 32'd1);
    ready_i = 2'b00;
    step(8);
    chk("d_stall1", 32'(stall0), 32'd2);
    done_i = 1'b1;
    step(1);
    done_i = 1'b0;
    chk("d_done_wins", 32'(st0), 32'd2);
    chk("d_quit", 32'(quit0), 32'd1);
    valid_i = 2'b00;
    do_clear();
    chk("d_clr_state", 32'(st0), 32'd0);
    chk("d_clr_addr", 32'(addr0), 32'd0);
    chk("d_clr_stall_quit", {29'd0, stall0, quit0}, 32'd0);
    start_i = 1'b1; clear_i = 1'b1;
    step(1);
    start_i = 1'b0; clear_i = 1'b0;
    chk("d_clear_beats_start", 32'(st0), 32'd0);
    step(1);
    chk("d_stays_idle", 32'(st0), 32'd0);

    // Timeout: counter reaches 100 after 100 RUN edges, exit on the next one
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    n = 0;
    while (st0 == 3'd1 && n < 200) begin
      step(1);
      n++;
    end
    chk("e_run_cycles", 32'(n), 32'd101);
    chk("e_timeout", 32'(st0), 32'd4);
    chk("e_quit", 32'(quit0), 32'd1);
    step(1);
    chk("e_quit_single", 32'(quit0), 32'd0);
    chk("e_sticky", 32'(st0), 32'd4);
    do_clear();

    // Asynchronous reset in the middle of a run
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    valid_i = 2'b01; ready_i = 2'b01;
    step(2);
    chk("f_addr_pre", 32'(addr0[1:0]), 32'd2);
    #2 rstn_nw = 1'b0;
    #1;
    chk("f_rst_state", 32'(st0), 32'd0);
    chk("f_rst_addr", 32'(addr0), 32'd0);
    chk("f_rst_quit_stall", {29'd0, stall0, quit0}, 32'd0);
    #2 rstn_nw = 1'b1;
    step(3);
    chk("f_idle_after", 32'(st0), 32'd0);
    chk("f_no_count_idle", 32'(addr0), 32'd0);
    valid_i = 2'b00; ready_i = 2'b00;
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    chk("f_restart", 32'(st0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_progress_monitor.md
STREAM_PROGRESS_MONITOR -- requirements
Module: stream_progress_monitor

Interface
REQ-001 SHALL have parameter NCH, default 4, number of monitored valid/ready channels (1..16).
REQ-002 SHALL have parameter FRAME_LEN, default 1024, handshakes per frame per channel (>=2); CNT_W = clog2(FRAME_LEN).
REQ-003 SHALL have parameter STALL_THRESH, default 1000000, no-progress cycles declaring a channel stalled (>=2, <2^24).
REQ-004 SHALL have parameter STALL_MODE, default 0: 0 = stall counted only mid-frame (addr!=0); 1 = stall counted whenever valid=1 and ready=0.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 2^32-1, RUN-state cycle budget.
REQ-006 SHALL have ports (name direction width meaning):
  clk_pc  in  1  monitor clock
  rstn_nw  in  1  reset, asynchronous, active-low
  start_i  in  1  IDLE->RUN request
  clear_i  in  1  synchronous return to IDLE, zero all counters
  valid_i  in  NCH  per-channel valid
  ready_i  in  NCH  per-channel ready
  done_i  in  1  all-tiles-done indication
  addr_o  out  NCH x CNT_W  per-channel in-frame handshake index
  frame_cnt_o  out  NCH x 16  per-channel completed frames, wraps 0xFFFF->0
  stall_o  out  NCH  per-channel stall flag
  state_o  out  3  0 IDLE, 1 RUN, 2 DONE, 3 DEADLOCK, 4 TIMEOUT
  quit_o  out  1  one-cycle pulse on entering DONE/DEADLOCK/TIMEOUT

Function
REQ-007 Handshake on channel i SHALL be valid_i[i] & ready_i[i] sampled at posedge clk_pc.
REQ-008 In RUN, a handshake SHALL increment addr_o[i]; at FRAME_LEN-1 it SHALL wrap to 0 and increment frame_cnt_o[i] in the same cycle.
REQ-009 Outside RUN, addr_o, frame_cnt_o and stall counters SHALL hold.
REQ-010 Per-channel stall counter SHALL clear on handshake; otherwise increment when the STALL_MODE condition holds; otherwise hold; saturate at STALL_THRESH.
REQ-011 stall_o[i] SHALL be registered, 1 iff stall counter == STALL_THRESH; cleared by next handshake on i (one-cycle latency).
REQ-012 Timeout counter SHALL count cycles in RUN, zeroed on IDLE->RUN, saturating at TIMEOUT_CYCLES.
REQ-013 IDLE->RUN SHALL occur the cycle after start_i=1 with clear_i=0; start_i ignored outside IDLE.
REQ-014 RUN SHALL exit, priority order: done_i=1 -> DONE; else any stall_o=1 -> DEADLOCK; else timeout counter == TIMEOUT_CYCLES -> TIMEOUT.
REQ-015 DONE, DEADLOCK, TIMEOUT SHALL be sticky until clear_i.
REQ-016 quit_o SHALL be 1 exactly in the first cycle state_o shows a terminal state.
REQ-017 clear_i=1 SHALL force IDLE and zero all counters, flags and quit_o next cycle from any state; clear_i wins over start_i and every exit condition.
REQ-018 A handshake in the cycle RUN exits SHALL still be counted; handshakes in the cycle IDLE->RUN SHALL not be counted.
REQ-019 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-020 rstn_nw=0 SHALL asynchronously force state_o=0, addr_o=0, frame_cnt_o=0, stall_o=0, quit_o=0, all internal counters 0.
REQ-021 Reset assertion mid-RUN SHALL abandon the frame; after release the block SHALL sit in IDLE until start_i.
REQ-022 rstn_nw release SHALL be synchronous to clk_pc externally; the block SHALL not resynchronise it.

Verification (NCH=2, FRAME_LEN=4, STALL_THRESH=8, TIMEOUT_CYCLES=100, STALL_MODE=0)
REQ-023 Start, ch0 valid=ready=1 for 9 cycles, ch1 idle -> addr_o[0]=1, frame_cnt_o[0]=2; ch1 unchanged, stall_o=0.
REQ-024 Start, ch0 3 handshakes then ready=0 with valid=1 -> stall_o[0]=1 at 8th non-progress cycle, state_o=3 next cycle, one quit_o pulse; addr_o[0]=3 holds.
REQ-025 Same stall with ch0 addr=0 (frame boundary) -> no stall, no DEADLOCK; repeat with STALL_MODE=1 -> DEADLOCK after 8 cycles.
REQ-026 done_i and stall_o[1] same cycle -> state_o=2 (DONE); clear_i -> state_o=0, all counters 0; start_i and clear_i together -> stays IDLE.
REQ-027 Start, no traffic, done_i=0 -> state_o=4 after 100 RUN cycles, single quit_o pulse; rstn_nw low mid-RUN -> all outputs 0 immediately, IDLE after release.
